game_state_ctrl: RTL
====================

Name: game_state_ctrl

Overview:
- Owns top-level game flow: menu, playing, hit-recovery, won, lost.
- Drives menuScreen/playerWon/playerLost into the obstacle/level counter.
- Consumes that counter's win pulse and obj_position_counter for collision detection.
- Sits between the input buttons/player logic and the level counter; outputs also feed VGA screen select.

Parameters:
- LIVES, 3, lives loaded on game start (1..3).
- PLAYER_X, 11'd100, fixed left edge of player sprite in pixels.
- PLAYER_W, 11'd20, player sprite width.
- OBJ_W, 11'd30, obstacle width.
- INVULN_CYCLES, 16, cycles of collision immunity after a non-fatal hit.
- HOLD_CYCLES, 60, cycles the WON/LOST screen is held before returning to menu.

Ports:
- clk  in  1  game tick clock
- reset  in  1  synchronous, active-low reset
- start_btn  in  1  start button, level, already synchronised
- player_airborne  in  1  1 = player mid-jump, so no collision is possible
- obj_position_counter  in  11  obstacle x position from level counter
- win  in  1  level-complete pulse from level counter
- menuScreen  out  1  1 in MENU state
- playerWon  out  1  1 in WON state
- playerLost  out  1  1 in LOST state
- lives  out  2  remaining lives
- score  out  8  obstacles passed, saturating

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=MENU, menuScreen=1, playerWon=0, playerLost=0.
  - lives=LIVES, score=0, timers=0, start_q=0.
- Start edge: start_q registers start_btn every cycle; start_rise = start_btn & ~start_q.
- Collision is combinational, with 12-bit zero-extended compares (no wrap):
  - hit = !player_airborne && (obj+OBJ_W > PLAYER_X) && (obj < PLAYER_X+PLAYER_W).
- Flag outputs are Moore decodes of the registered state, visible the cycle after the transition edge.
- MENU:
  - On start_rise, go to PLAY; load lives=LIVES and score=0.
  - A held button does not retrigger.
- PLAY, priority order:
  - win: go to WON; win beats hit in the same cycle.
  - hit with lives==1: lives=0, go to LOST.
  - hit with lives>1: lives-1, go to HIT, load inv_cnt=INVULN_CYCLES-1.
- HIT:
  - hit is ignored.
  - win goes to WON.
  - inv_cnt decrements; at 0, go to PLAY.
- WON/LOST:
  - On entry, load hold_cnt=HOLD_CYCLES-1; decrement each cycle.
  - At 0, go to MENU.
  - start_rise is ignored.
- Score:
  - Applies in PLAY and HIT only.
  - A wrap is detected when obj_position_counter==0 and the registered previous value !=0.
  - Each wrap increments score, saturating at 255.
- Level counter interaction:
  - The level counter clears itself while any flag is high, so a WON/LOST hold of >=1 cycle guarantees the level restarts from 0.
- Reset mid-game forces MENU and all reset values within one cycle, regardless of timers.
- Only one of menuScreen/playerWon/playerLost is high at a time. All three are 0 in PLAY and HIT.

Optional Feature:
- Macro: GAME_LIVES_EN.
- Defined:
  - Multi-life behaviour as above.
  - HIT state and INVULN_CYCLES are active.
- Undefined:
  - Single life: any hit in PLAY goes directly to LOST.
  - HIT state and invulnerability logic are not synthesised.
  - lives output is tied to 2'd1.
  - LIVES and INVULN_CYCLES are ignored.

Test Plan:
- Reset, then start_btn held high for 10 cycles: exactly one MENU->PLAY transition; menuScreen falls one cycle after the first rising edge; lives=3, score=0.
- PLAY, player_airborne=0, obj=11'd80 (overlaps the default player at 100..119): lives 3->2, state HIT. obj held at 80 for 16 cycles gives no further decrement; back to PLAY after 16 cycles.
- PLAY, same cycle win=1 and a colliding obj: WON entered, lives unchanged, playerWon=1 for 60 cycles, then menuScreen=1.
- Three separated collisions, each after invulnerability expires: lives 3->2->1->0; playerLost=1 after the third. With GAME_LIVES_EN undefined, the first collision gives playerLost=1 and lives stays 1.
- obj sequence 690, 0 repeated 300 times in PLAY: score saturates at 255. The collision with player_airborne=1 at obj=100 causes no lives change.
- Pulse reset low during LOST with hold_cnt=30: next cycle menuScreen=1, playerLost=0, lives=3, score=0.

Source files
------------

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: top-level game flow (menu, play, hit-recovery, won, lost) with lives and score.
// Define GAME_LIVES_EN for multi-life play with a post-hit invulnerability window.
module game_state_ctrl #(
  parameter int unsigned LIVES         = 3,
  parameter logic [10:0] PLAYER_X      = 11'd100,
  parameter logic [10:0] PLAYER_W      = 11'd20,
  parameter logic [10:0] OBJ_W         = 11'd30,
  parameter int unsigned INVULN_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        player_airborne,
  input  logic [10:0] obj_position_counter,
  input  logic        win,
  output logic        menuScreen,
  output logic        playerWon,
  output logic        playerLost,
  output logic [1:0]  lives,
  output logic [7:0]  score
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_MENU = 3'd0,
    ST_PLAY = 3'd1,
`ifdef GAME_LIVES_EN
    ST_HIT  = 3'd2,
`endif
    ST_WON  = 3'd3,
    ST_LOST = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                start_q;
  logic [10:0]         obj_prev_q;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [7:0]          score_q, score_d;
  logic                start_rise, hit, wrap, in_recovery;

  assign start_rise = start_btn & ~start_q;
  // 12-bit compares so obj + OBJ_W near the right edge cannot wrap into a false hit
  assign hit = !player_airborne
             && (({1'b0, obj_position_counter} + {1'b0, OBJ_W}) > {1'b0, PLAYER_X})
             && ({1'b0, obj_position_counter} < ({1'b0, PLAYER_X} + {1'b0, PLAYER_W}));
  assign wrap = (obj_position_counter == 11'd0) && (obj_prev_q != 11'd0);

`ifdef GAME_LIVES_EN
  localparam int unsigned INV_W = $clog2(INVULN_CYCLES + 1);
  logic [1:0]       lives_q, lives_d;
  logic [INV_W-1:0] inv_q, inv_d;
  assign in_recovery = (state_q == ST_HIT);
  assign lives       = lives_q;
`else
  logic unused_params;
  assign unused_params = ^{LIVES, INVULN_CYCLES};
  assign in_recovery   = 1'b0;
  assign lives         = 2'd1;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    score_d = score_q;
`ifdef GAME_LIVES_EN
    lives_d = lives_q;
    inv_d   = inv_q;
`endif
    case (state_q)
      ST_MENU: begin
        if (start_rise) begin
          state_d = ST_PLAY;
          score_d = 8'd0;
`ifdef GAME_LIVES_EN
          lives_d = 2'(LIVES);
`endif
        end
      end
      ST_PLAY: begin
        if (win) begin
          state_d = ST_WON;
          hold_d  = HOLD_W'(HOLD_CYCLES - 1);
        end else if (hit) begin
`ifdef GAME_LIVES_EN
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = ST_LOST;
            hold_d  = HOLD_W'(HOLD_CYCLES - 1);
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = ST_HIT;
            inv_d   = INV_W'(INVULN_CYCLES - 1);
          end
`else
          state_d = ST_LOST;
          hold_d  = HOLD_W'(HOLD_CYCLES - 1);
`endif
        end
      end
`ifdef GAME_LIVES_EN
      ST_HIT: begin
        if (win) begin
          state_d = ST_WON;
          hold_d  = HOLD_W'(HOLD_CYCLES - 1);
        end else if (inv_q == '0) begin
          state_d = ST_PLAY;
        end else begin
          inv_d = inv_q - 1'b1;
        end
      end
`endif
      ST_WON, ST_LOST: begin
        if (hold_q == '0) state_d = ST_MENU;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = ST_MENU;
    endcase
    // score counts obstacle wraps only while the player is in the level
    if ((state_q == ST_PLAY || in_recovery) && wrap && (score_q != 8'hFF))
      score_d = score_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_MENU;
      start_q    <= 1'b0;
      obj_prev_q <= 11'd0;
      hold_q     <= '0;
      score_q    <= 8'd0;
`ifdef GAME_LIVES_EN
      lives_q    <= 2'(LIVES);
      inv_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_btn;
      obj_prev_q <= obj_position_counter;
      hold_q     <= hold_d;
      score_q    <= score_d;
`ifdef GAME_LIVES_EN
      lives_q    <= lives_d;
      inv_q      <= inv_d;
`endif
    end
  end

  assign menuScreen = (state_q == ST_MENU);
  assign playerWon  = (state_q == ST_WON);
  assign playerLost = (state_q == ST_LOST);
  assign score      = score_q;

endmodule
